// File: rtl/apb_mc_pkg.sv
// apb_mc_pkg
// Shared types and elaboration-time helpers for the multi-slave APB master.
//   state_t    : one-hot master FSM encoding (IDLE, SETUP, ACCESS, RESP)
//   clog2      : ceiling log2 for parameter derivation
//   sel_width  : width of the slave index field, never less than 1
package apb_mc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_SETUP  = 4'b0010,
        ST_ACCESS = 4'b0100,
        ST_RESP   = 4'b1000
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int sel_width(input int num_slaves);
        return (clog2(num_slaves) < 1) ? 1 : clog2(num_slaves);
    endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// apb_slave_decode
// Combinational slave decode from the top SEL_W address bits.
// Ports:
//   addr       in  ADDR_W      command address
//   sel        out NUM_SLAVES  one-hot select, all zero on decode error
//   index      out SEL_W       raw slave index field
//   decode_err out 1           index does not map to an existing slave
module apb_slave_decode
    import apb_mc_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int NUM_SLAVES = 2,
    parameter int SEL_W      = sel_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic [SEL_W-1:0]      index,
    output logic                  decode_err
);

    always_comb begin
        index      = addr[ADDR_W-1 -: SEL_W];
        // Also covers NUM_SLAVES == 1: any set index bit lands at or above 1.
        decode_err = (int'(index) >= NUM_SLAVES);
        sel        = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!decode_err && (int'(index) == i)) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_mc.sv
// apb_master_mc
// Single-outstanding APB master driving NUM_SLAVES peripherals. A command
// taken on the valid/ready port becomes one SETUP/ACCESS transfer; the
// outcome (read data, slave error, decode error, timeout) is reported on a
// one-cycle rsp_valid pulse.
// Ports:
//   PCLK, PRESET                    clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata command port
//   rsp_valid/rdata/err/timeout     response port (fields hold between pulses)
//   PSEL, PENABLE, PADDR, PWRITE, PWDATA   registered APB requester outputs
//   PRDATA, PREADY, PSLVERR         per-slave completer inputs
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSEL asserted, PENABLE low for one cycle
// ACCESS | PENABLE high, waiting for PREADY of the selected slave
// RESP   | drive captured result onto rsp_* with rsp_valid next cycle
module apb_master_mc
    import apb_mc_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int NUM_SLAVES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [DATA_W-1:0]            cmd_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_timeout,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic [ADDR_W-1:0]            PADDR,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int SEL_W      = sel_width(NUM_SLAVES);
    localparam int CNT_W      = (TIMEOUT < 2) ? 1 : clog2(TIMEOUT);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [ADDR_W-1:0]       paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_W-1:0]       pwdata_q, pwdata_d;
    logic [SEL_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        wait_q, wait_d;
    logic [DATA_W-1:0]       cap_rdata_q, cap_rdata_d;
    logic                    cap_err_q, cap_err_d;
    logic                    cap_to_q, cap_to_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_to_q, rsp_to_d;

    logic [NUM_SLAVES-1:0]   dec_sel;
    logic [SEL_W-1:0]        dec_idx;
    logic                    dec_err;
    logic [DATA_W-1:0]       prdata_arr [NUM_SLAVES];

    apb_slave_decode #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_W      (SEL_W)
    ) u_decode (
        .addr       (cmd_addr),
        .sel        (dec_sel),
        .index      (dec_idx),
        .decode_err (dec_err)
    );

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_prdata
        assign prdata_arr[g] = PRDATA[g*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        cap_rdata_d = cap_rdata_q;
        cap_err_d   = cap_err_q;
        cap_to_d    = cap_to_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    idx_d    = dec_idx;
                    // Reads leave PWDATA alone to avoid needless toggling.
                    if (cmd_write) begin
                        pwdata_d = cmd_wdata;
                    end
                    if (dec_err) begin
                        cap_rdata_d = '0;
                        cap_err_d   = 1'b1;
                        cap_to_d    = 1'b0;
                        state_d     = ST_RESP;
                    end else begin
                        psel_d    = dec_sel;
                        penable_d = 1'b0;
                        state_d   = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                wait_d    = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY[idx_q]) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    cap_err_d   = PSLVERR[idx_q];
                    cap_to_d    = 1'b0;
                    cap_rdata_d = (!pwrite_q && !PSLVERR[idx_q]) ? prdata_arr[idx_q] : '0;
                    state_d     = ST_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
                        psel_d      = '0;
                        penable_d   = 1'b0;
                        cap_err_d   = 1'b1;
                        cap_to_d    = 1'b1;
                        cap_rdata_d = '0;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = cap_rdata_q;
                rsp_err_d   = cap_err_q;
                rsp_to_d    = cap_to_q;
                state_d     = ST_IDLE;
            end
            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            idx_q       <= '0;
            wait_q      <= '0;
            cap_rdata_q <= '0;
            cap_err_q   <= 1'b0;
            cap_to_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            cap_rdata_q <= cap_rdata_d;
            cap_err_q   <= cap_err_d;
            cap_to_q    <= cap_to_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_apb_master_mc.sv
// tb_apb_master_mc
// Directed bench for apb_master_mc. Instance a uses default parameters,
// instance b uses NUM_SLAVES=3, TIMEOUT=4 for timeout and decode-error cases.
module tb_apb_master_mc;

    logic PCLK = 1'b0;
    logic PRESET;

    logic        a_cmd_valid, a_cmd_ready, a_cmd_write;
    logic [7:0]  a_cmd_addr, a_cmd_wdata;
    logic        a_rsp_valid, a_rsp_err, a_rsp_timeout;
    logic [7:0]  a_rsp_rdata;
    logic [1:0]  a_psel;
    logic        a_penable, a_pwrite;
    logic [7:0]  a_paddr, a_pwdata;
    logic [15:0] a_prdata;
    logic [1:0]  a_pready, a_pslverr;

    logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
    logic [7:0]  b_cmd_addr, b_cmd_wdata;
    logic        b_rsp_valid, b_rsp_err, b_rsp_timeout;
    logic [7:0]  b_rsp_rdata;
    logic [2:0]  b_psel;
    logic        b_penable, b_pwrite;
    logic [7:0]  b_paddr, b_pwdata;
    logic [23:0] b_prdata;
    logic [2:0]  b_pready, b_pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 PCLK = ~PCLK;

    apb_master_mc dut_a (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
        .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .rsp_timeout(a_rsp_timeout),
        .PSEL(a_psel), .PENABLE(a_penable), .PADDR(a_paddr), .PWRITE(a_pwrite),
        .PWDATA(a_pwdata), .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr)
    );

    apb_master_mc #(.ADDR_W(8), .DATA_W(8), .NUM_SLAVES(3), .TIMEOUT(4)) dut_b (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
        .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .rsp_timeout(b_rsp_timeout),
        .PSEL(b_psel), .PENABLE(b_penable), .PADDR(b_paddr), .PWRITE(b_pwrite),
        .PWDATA(b_pwdata), .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
    );

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Latency in edges after the accept edge; -1 if no response within the bound.
    task automatic wait_rsp_a(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (a_rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_rsp_b(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (b_rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        a_cmd_valid = 0; a_cmd_write = 0; a_cmd_addr = 0; a_cmd_wdata = 0;
        a_prdata = 0; a_pready = 0; a_pslverr = 0;
        b_cmd_valid = 0; b_cmd_write = 0; b_cmd_addr = 0; b_cmd_wdata = 0;
        b_prdata = 0; b_pready = 0; b_pslverr = 0;
        repeat (3) tick();
        PRESET = 1'b0;
        tick();
        n_checks++; if (a_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b expected 1", a_cmd_ready); end
        n_checks++; if (a_psel !== 2'b00) begin n_fail++; $display("FAIL rst_psel: got %b expected 00", a_psel); end
        n_checks++; if (a_penable !== 1'b0) begin n_fail++; $display("FAIL rst_penable: got %b expected 0", a_penable); end
        n_checks++; if (a_paddr !== 8'h00) begin n_fail++; $display("FAIL rst_paddr: got %h expected 00", a_paddr); end
        n_checks++; if (a_pwrite !== 1'b0) begin n_fail++; $display("FAIL rst_pwrite: got %b expected 0", a_pwrite); end
        n_checks++; if (a_pwdata !== 8'h00) begin n_fail++; $display("FAIL rst_pwdata: got %h expected 00", a_pwdata); end
        n_checks++; if ({a_rsp_valid, a_rsp_err, a_rsp_timeout} !== 3'b000) begin n_fail++; $display("FAIL rst_rsp_flags: got %b expected 000", {a_rsp_valid, a_rsp_err, a_rsp_timeout}); end
        n_checks++; if (a_rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h expected 00", a_rsp_rdata); end
        n_checks++; if ({b_cmd_ready, b_psel} !== 4'b1000) begin n_fail++; $display("FAIL rst_b_ready_psel: got %b expected 1000", {b_cmd_ready, b_psel}); end
    endtask

    task automatic test_write_zero_wait();
        a_pready = 2'b11;
        a_cmd_valid = 1; a_cmd_write = 1; a_cmd_addr = 8'h85; a_cmd_wdata = 8'h3C;
        tick();
        a_cmd_valid = 0;
        n_checks++; if (a_psel !== 2'b10) begin n_fail++; $display("FAIL wr_setup_psel: got %b expected 10", a_psel); end
        n_checks++; if (a_penable !== 1'b0) begin n_fail++; $display("FAIL wr_setup_penable: got %b expected 0", a_penable); end
        n_checks++; if ({a_paddr, a_pwdata, a_pwrite} !== {8'h85, 8'h3C, 1'b1}) begin n_fail++; $display("FAIL wr_setup_bus: got %h/%h/%b expected 85/3c/1", a_paddr, a_pwdata, a_pwrite); end
        n_checks++; if (a_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wr_busy_ready: got %b expected 0", a_cmd_ready); end
        tick();
        n_checks++; if ({a_psel, a_penable} !== 3'b101) begin n_fail++; $display("FAIL wr_access: got %b expected 101", {a_psel, a_penable}); end
        tick();
        n_checks++; if ({a_psel, a_penable, a_rsp_valid} !== 4'b0000) begin n_fail++; $display("FAIL wr_done: got %b expected 0000", {a_psel, a_penable, a_rsp_valid}); end
        n_checks++; if (a_paddr !== 8'h85) begin n_fail++; $display("FAIL wr_paddr_hold: got %h expected 85", a_paddr); end
        tick();
        n_checks++; if ({a_rsp_valid, a_rsp_err, a_rsp_timeout} !== 3'b100) begin n_fail++; $display("FAIL wr_rsp: got %b expected 100", {a_rsp_valid, a_rsp_err, a_rsp_timeout}); end
        n_checks++; if (a_rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL wr_rsp_rdata: got %h expected 00", a_rsp_rdata); end
        tick();
        n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_pulse: got %b expected 0", a_rsp_valid); end
    endtask

    task automatic test_read_wait();
        a_prdata = {8'h77, 8'hA5};
        a_pready = 2'b11;
        a_cmd_valid = 1; a_cmd_write = 0; a_cmd_addr = 8'h12; a_cmd_wdata = 8'hEE;
        tick();
        a_cmd_valid = 0;
        n_checks++; if ({a_psel, a_pwrite} !== 3'b010) begin n_fail++; $display("FAIL rd_setup: got %b expected 010", {a_psel, a_pwrite}); end
        n_checks++; if ({a_paddr, a_pwdata} !== {8'h12, 8'h3C}) begin n_fail++; $display("FAIL rd_setup_bus: got %h/%h expected 12/3c", a_paddr, a_pwdata); end
        tick();
        // Ready from the non-selected slave only during the wait states.
        a_pready = 2'b10;
        tick();
        n_checks++; if ({a_psel, a_penable} !== 3'b011) begin n_fail++; $display("FAIL rd_wait1: got %b expected 011", {a_psel, a_penable}); end
        tick();
        n_checks++; if ({a_psel, a_rsp_valid} !== 3'b010) begin n_fail++; $display("FAIL rd_wait2: got %b expected 010", {a_psel, a_rsp_valid}); end
        a_pready = 2'b01;
        tick();
        n_checks++; if ({a_psel, a_rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL rd_done: got %b expected 000", {a_psel, a_rsp_valid}); end
        tick();
        n_checks++; if ({a_rsp_valid, a_rsp_err} !== 2'b10) begin n_fail++; $display("FAIL rd_rsp: got %b expected 10", {a_rsp_valid, a_rsp_err}); end
        n_checks++; if (a_rsp_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_rdata: got %h expected a5", a_rsp_rdata); end
        tick();
    endtask

    task automatic test_pslverr();
        int lat;
        a_pready = 2'b11; a_pslverr = 2'b10;
        a_cmd_valid = 1; a_cmd_write = 0; a_cmd_addr = 8'h9A;
        tick();
        a_cmd_valid = 0;
        wait_rsp_a(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL err_latency: got %0d expected 3", lat); end
        n_checks++; if ({a_rsp_err, a_rsp_timeout} !== 2'b10) begin n_fail++; $display("FAIL err_flags: got %b expected 10", {a_rsp_err, a_rsp_timeout}); end
        n_checks++; if (a_rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL err_rdata: got %h expected 00", a_rsp_rdata); end
        tick();
        a_cmd_valid = 1; a_cmd_addr = 8'h12;
        tick();
        a_cmd_valid = 0;
        wait_rsp_a(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL other_err_latency: got %0d expected 3", lat); end
        n_checks++; if ({a_rsp_err, a_rsp_rdata} !== {1'b0, 8'hA5}) begin n_fail++; $display("FAIL other_err_ignored: got %b/%h expected 0/a5", a_rsp_err, a_rsp_rdata); end
        a_pslverr = 2'b00;
        tick();
    endtask

    task automatic test_timeout();
        b_pready = 3'b000; b_prdata = 24'h00_5500;
        b_cmd_valid = 1; b_cmd_write = 0; b_cmd_addr = 8'h40;
        tick();
        b_cmd_valid = 0;
        n_checks++; if (b_psel !== 3'b010) begin n_fail++; $display("FAIL to_setup_psel: got %b expected 010", b_psel); end
        repeat (4) tick();
        n_checks++; if ({b_psel, b_penable} !== 4'b0101) begin n_fail++; $display("FAIL to_last_wait: got %b expected 0101", {b_psel, b_penable}); end
        tick();
        n_checks++; if ({b_psel, b_penable, b_rsp_valid} !== 5'b00000) begin n_fail++; $display("FAIL to_abort: got %b expected 00000", {b_psel, b_penable, b_rsp_valid}); end
        tick();
        n_checks++; if ({b_rsp_valid, b_rsp_err, b_rsp_timeout} !== 3'b111) begin n_fail++; $display("FAIL to_rsp: got %b expected 111", {b_rsp_valid, b_rsp_err, b_rsp_timeout}); end
        n_checks++; if (b_rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL to_rdata: got %h expected 00", b_rsp_rdata); end
        tick();
    endtask

    task automatic test_decode();
        int lat;
        b_cmd_valid = 1; b_cmd_write = 1; b_cmd_addr = 8'hC0; b_cmd_wdata = 8'h11;
        tick();
        b_cmd_valid = 0;
        n_checks++; if ({b_psel, b_cmd_ready} !== 4'b0000) begin n_fail++; $display("FAIL dec_no_psel: got %b expected 0000", {b_psel, b_cmd_ready}); end
        tick();
        n_checks++; if ({b_rsp_valid, b_rsp_err, b_rsp_timeout} !== 3'b110) begin n_fail++; $display("FAIL dec_rsp: got %b expected 110", {b_rsp_valid, b_rsp_err, b_rsp_timeout}); end
        n_checks++; if (b_rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL dec_rdata: got %h expected 00", b_rsp_rdata); end
        tick();
        b_pready = 3'b100; b_prdata = {8'hC3, 8'h55, 8'h11};
        b_cmd_valid = 1; b_cmd_write = 0; b_cmd_addr = 8'h80;
        tick();
        b_cmd_valid = 0;
        n_checks++; if (b_psel !== 3'b100) begin n_fail++; $display("FAIL slv2_psel: got %b expected 100", b_psel); end
        wait_rsp_b(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL slv2_latency: got %0d expected 3", lat); end
        n_checks++; if ({b_rsp_err, b_rsp_rdata} !== {1'b0, 8'hC3}) begin n_fail++; $display("FAIL slv2_rsp: got %b/%h expected 0/c3", b_rsp_err, b_rsp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        int lat;
        a_pready = 2'b00;
        a_cmd_valid = 1; a_cmd_write = 0; a_cmd_addr = 8'h12;
        tick();
        a_cmd_valid = 0;
        tick();
        tick();
        n_checks++; if ({a_psel, a_penable} !== 3'b011) begin n_fail++; $display("FAIL rm_in_access: got %b expected 011", {a_psel, a_penable}); end
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        n_checks++; if ({a_psel, a_penable, a_rsp_valid, a_cmd_ready} !== 5'b00001) begin n_fail++; $display("FAIL rm_abort: got %b expected 00001", {a_psel, a_penable, a_rsp_valid, a_cmd_ready}); end
        a_pready = 2'b11;
        a_cmd_valid = 1; a_cmd_write = 1; a_cmd_addr = 8'h05; a_cmd_wdata = 8'h5A;
        tick();
        a_cmd_valid = 0;
        n_checks++; if ({a_psel, a_pwdata, a_rsp_valid} !== {2'b01, 8'h5A, 1'b0}) begin n_fail++; $display("FAIL rm_new_setup: got %b/%h/%b expected 01/5a/0", a_psel, a_pwdata, a_rsp_valid); end
        wait_rsp_a(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rm_new_latency: got %0d expected 3", lat); end
        n_checks++; if (a_rsp_err !== 1'b0) begin n_fail++; $display("FAIL rm_new_err: got %b expected 0", a_rsp_err); end
        tick();
    endtask

    task automatic test_back_to_back();
        int accepts;
        int rsps;
        accepts = 0;
        rsps = 0;
        a_pready = 2'b11; a_prdata = {8'h77, 8'hA5};
        a_cmd_valid = 1; a_cmd_write = 0; a_cmd_addr = 8'h12;
        for (int i = 0; i < 8; i++) begin
            if (a_cmd_ready === 1'b1) accepts++;
            tick();
            if (a_rsp_valid === 1'b1) rsps++;
        end
        a_cmd_valid = 0;
        n_checks++; if (accepts !== 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", accepts); end
        n_checks++; if (rsps !== 2) begin n_fail++; $display("FAIL b2b_rsps: got %0d expected 2", rsps); end
        rsps = 0;
        repeat (4) begin
            tick();
            if (a_rsp_valid === 1'b1) rsps++;
        end
        n_checks++; if (rsps !== 0) begin n_fail++; $display("FAIL b2b_no_extra: got %0d expected 0", rsps); end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_pslverr();
        test_timeout();
        test_decode();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
